// File: rtl/conv_l1_out_stage.sv
// conv_l1_out_stage
//   Output stage for the layer-1 3x3 systolic convolution. It re-times the
//   input-pixel valid/sof flags so that they line up with the conv result
//   stream, and it tracks the (row, col) position of each result. Border
//   results, which come from partial windows, are dropped. Each full-window
//   result is requantized to an unsigned 8-bit activation:
//     bias add -> ReLU -> round half up -> right shift -> saturate.
//   Requantized results are queued in a 4-entry FIFO that feeds the next
//   layer through a valid/ready handshake.
//
//   Optional feature: define CONV_L1_OUT_STATS_EN to add the sat_count output.
//
// Ports
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous active-high reset
//   pxl_in_valid in   1   pixel entering the conv stage is valid
//   pxl_in_sof   in   1   with pxl_in_valid: pixel is (0,0) of a frame
//   conv_in      in   16  signed conv result, PIPE_LAT cycles after its pixel
//   bias         in   16  signed bias, held stable for a whole frame
//   out_data     out  8   FIFO head (0 when empty)
//   out_valid    out  1   FIFO not empty
//   out_ready    in   1   consumer takes out_data when out_valid && out_ready
//   frame_done   out  1   pulse after the last result of a frame
//   overflow     out  1   sticky, set when a kept result is dropped on a full FIFO
//   sat_count    out  16  (CONV_L1_OUT_STATS_EN only) kept results clipped to 255
module conv_l1_out_stage #(
   parameter int IMG_W    = 28,
   parameter int IMG_H    = 28,
   parameter int K        = 3,
   parameter int PIPE_LAT = 1,
   parameter int SHIFT    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pxl_in_valid,
   input  logic        pxl_in_sof,
   input  logic [15:0] conv_in,
   input  logic [15:0] bias,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        frame_done,
   output logic        overflow
`ifdef CONV_L1_OUT_STATS_EN
   ,
   output logic [15:0] sat_count
`endif
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
   localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);
   localparam logic [17:0]   RND      = (SHIFT > 0) ? (18'd1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 18'd0;

   // valid/sof delay lines, aligned with conv_in at the tap PIPE_LAT-1
   logic [PIPE_LAT-1:0] valid_sr;
   logic [PIPE_LAT-1:0] sof_sr;
   logic                a_valid;
   logic                a_sof;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_sr <= '0;
         sof_sr   <= '0;
      end else begin
         valid_sr[0] <= pxl_in_valid;
         sof_sr[0]   <= pxl_in_valid & pxl_in_sof;
         for (int i = 1; i < PIPE_LAT; i++) begin
            valid_sr[i] <= valid_sr[i-1];
            sof_sr[i]   <= sof_sr[i-1];
         end
      end
   end

   assign a_valid = valid_sr[PIPE_LAT-1];
   assign a_sof   = a_valid & sof_sr[PIPE_LAT-1];

   // Position tracking. row_reg/col_reg hold the expected position of the
   // next result. A result that carries sof is (0,0) by definition, whatever
   // the counters say.
   logic [RW-1:0] row_reg, row_next, cur_row;
   logic [CW-1:0] col_reg, col_next, cur_col;
   logic          at_last;
   logic          keep;

   assign cur_row = a_sof ? '0 : row_reg;
   assign cur_col = a_sof ? '0 : col_reg;
   assign at_last = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
   assign keep    = a_valid && (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);

   always_comb begin
      row_next = cur_row;
      col_next = cur_col + CW'(1);
      if (at_last) begin
         row_next = '0;
         col_next = '0;
      end else if (cur_col == COL_LAST) begin
         row_next = cur_row + RW'(1);
         col_next = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_reg <= '0;
         col_reg <= '0;
      end else if (a_valid) begin
         row_reg <= row_next;
         col_reg <= col_next;
      end
   end

   // Requantization. The sum is non-negative whenever the shifted path is
   // used, so the 18-bit logical shift matches an arithmetic one.
   logic [16:0] sum;
   logic [17:0] rounded;
   logic [17:0] shifted;
   logic        sat;
   logic [7:0]  q;

   assign sum     = {conv_in[15], conv_in} + {bias[15], bias};
   assign rounded = {1'b0, sum} + RND;
   assign shifted = rounded >> SHIFT;
   assign sat     = !sum[16] && (shifted > 18'd255);
   assign q       = sum[16] ? 8'd0 : (sat ? 8'd255 : shifted[7:0]);

   // 4-entry FIFO. When the FIFO is full, a pop in the same cycle frees the
   // slot that the push needs.
   logic [7:0] mem [4];
   logic [1:0] wr_ptr_reg;
   logic [1:0] rd_ptr_reg;
   logic [2:0] count_reg;
   logic       pop;
   logic       push;
   logic       drop;

   assign pop  = (count_reg != 3'd0) && out_ready;
   assign push = keep && ((count_reg != 3'd4) || pop);
   assign drop = keep && (count_reg == 3'd4) && !pop;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
         if (push && !pop)      count_reg <= count_reg + 3'd1;
         else if (pop && !push) count_reg <= count_reg - 3'd1;
      end
   end

   assign out_valid = (count_reg != 3'd0);
   assign out_data  = out_valid ? mem[rd_ptr_reg] : 8'd0;

   logic frame_done_reg;
   logic overflow_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_done_reg <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         frame_done_reg <= a_valid && at_last;
         overflow_reg   <= overflow_reg | drop;
      end
   end

   assign frame_done = frame_done_reg;
   assign overflow   = overflow_reg;

`ifdef CONV_L1_OUT_STATS_EN
   // Counts every saturated kept result, including results the FIFO drops.
   logic [15:0] sat_reg;
   logic [15:0] sat_base;

   assign sat_base = a_sof ? 16'd0 : sat_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sat_reg <= '0;
      end else if (keep && sat && (sat_base != 16'hFFFF)) begin
         sat_reg <= sat_base + 16'd1;
      end else begin
         sat_reg <= sat_base;
      end
   end

   assign sat_count = sat_reg;
`endif

endmodule

// File: tb/tb_conv_l1_out_stage.sv
module tb_conv_l1_out_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        pxl_in_valid;
   logic        pxl_in_sof;
   logic [15:0] conv_in;
   logic [15:0] bias;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        frame_done;
   logic        overflow;
`ifdef CONV_L1_OUT_STATS_EN
   logic [15:0] sat_count;
`endif

   conv_l1_out_stage #(
      .IMG_W(5), .IMG_H(5), .K(3), .PIPE_LAT(1), .SHIFT(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pxl_in_valid(pxl_in_valid),
      .pxl_in_sof(pxl_in_sof),
      .conv_in(conv_in),
      .bias(bias),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .frame_done(frame_done),
      .overflow(overflow)
`ifdef CONV_L1_OUT_STATS_EN
      ,
      .sat_count(sat_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // scoreboard / reference state
   logic [7:0]  mq[$];
   logic        m_ovf = 1'b0;
   logic        exp_fd = 1'b0;
   int          m_sat = 0;
   int          mrow = 0, mcol = 0;
   logic        pend_valid = 1'b0, pend_keep = 1'b0, pend_last = 1'b0, pend_sof = 1'b0, pend_sat = 1'b0;
   logic [15:0] pend_cv = '0;
   logic [7:0]  pend_q = '0;
   int          pop_cnt = 0;
   int          fd_seen = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // returns {saturated, q} for SHIFT=4
   function automatic logic [8:0] quant(input logic [15:0] c, input logic [15:0] b);
      int s;
      s = int'($signed(c)) + int'($signed(b));
      if (s < 0) return 9'd0;
      s = (s + 8) / 16;
      if (s > 255) return {1'b1, 8'd255};
      return {1'b0, s[7:0]};
   endfunction

   // One clock cycle: check state left by the previous edge, drive the new
   // pixel plus the conv result of the previous pixel, and advance the model
   // over the coming edge.
   task automatic cycle(input logic v, input logic sof, input logic [15:0] cv, input logic rdy);
      int r, c;
      logic [8:0] qq;
      @(negedge clk);
      check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      check("out_data", {24'd0, out_data}, {24'd0, (mq.size() != 0) ? mq[0] : 8'd0});
      check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef CONV_L1_OUT_STATS_EN
      check("sat_count", {16'd0, sat_count}, m_sat);
`endif
      if (frame_done) fd_seen++;
      pxl_in_valid = v;
      pxl_in_sof   = v & sof;
      conv_in      = pend_cv;
      out_ready    = rdy;
      if (mq.size() != 0 && rdy) begin
         $display("OUT data=%0d", mq[0]);
         void'(mq.pop_front());
         pop_cnt++;
      end
      exp_fd = pend_valid && pend_last;
      if (pend_keep) begin
         if (mq.size() < 4) mq.push_back(pend_q);
         else m_ovf = 1'b1;
      end
      if (pend_valid && pend_sof) m_sat = 0;
      if (pend_keep && pend_sat && m_sat < 65535) m_sat++;
      pend_valid = v;
      pend_keep  = 1'b0;
      pend_last  = 1'b0;
      pend_sof   = v & sof;
      pend_cv    = cv;
      qq         = quant(cv, bias);
      pend_q     = qq[7:0];
      pend_sat   = qq[8];
      if (v) begin
         if (sof) begin r = 0; c = 0; end
         else begin r = mrow; c = mcol; end
         pend_keep = (r >= 2) && (c >= 2);
         pend_last = (r == 4) && (c == 4);
         if (pend_last) begin mrow = 0; mcol = 0; end
         else if (c == 4) begin mrow = r + 1; mcol = 0; end
         else begin mrow = r; mcol = c + 1; end
      end
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'd0, rdy);
   endtask

   // conv_mode: 0 const 160, 1 const -100, 2 spot values + random
   // rdy_mode: 0 ready, 1 stalled, 2 stalled until pixel 18, 3 random
   task automatic drive_frame(input int n, input int restart, input int conv_mode, input int rdy_mode);
      logic [15:0] cv;
      logic        rdy;
      for (int j = 0; j < n; j++) begin
         case (conv_mode)
            0: cv = 16'd160;
            1: cv = 16'hFF9C;
            default: cv = (j == 12) ? 16'd24 : (j == 13) ? 16'd5000 :
                          (j == 14) ? 16'd23 : 16'($urandom);
         endcase
         case (rdy_mode)
            0: rdy = 1'b1;
            1: rdy = 1'b0;
            2: rdy = (j > 18);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         cycle(1'b1, (j == 0) || (j == restart), cv, rdy);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      pxl_in_valid = 1'b0;
      pxl_in_sof = 1'b0;
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      mq.delete();
      m_ovf = 1'b0; exp_fd = 1'b0; m_sat = 0; mrow = 0; mcol = 0;
      pend_valid = 1'b0; pend_keep = 1'b0; pend_last = 1'b0; pend_sof = 1'b0; pend_sat = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      pxl_in_valid = 1'b0;
      pxl_in_sof = 1'b0;
      conv_in = '0;
      bias = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("init_out_valid", {31'd0, out_valid}, 32'd0);
      check("init_out_data", {24'd0, out_data}, 32'd0);
      check("init_frame_done", {31'd0, frame_done}, 32'd0);
      check("init_overflow", {31'd0, overflow}, 32'd0);
      reset = 1'b0;

      // full frame, constant 160 -> nine 10s and one frame_done
      pop_cnt = 0; fd_seen = 0;
      drive_frame(25, -1, 0, 0);
      idle(4, 1'b1);
      check("f1_outputs", pop_cnt, 9);
      check("f1_frame_done", fd_seen, 1);

      // ReLU case
      bias = 16'd50; pop_cnt = 0;
      drive_frame(25, -1, 1, 0);
      idle(4, 1'b1);
      check("relu_outputs", pop_cnt, 9);

      // rounding and saturation spot values plus random results
      bias = 16'd0; pop_cnt = 0;
      drive_frame(25, -1, 2, 0);
      idle(4, 1'b1);
      check("arith_outputs", pop_cnt, 9);

      // random bias and random back-pressure
      bias = 16'($urandom_range(0, 600)) - 16'd300;
      drive_frame(25, -1, 2, 3);
      idle(8, 1'b1);

      // consumer stalled for a whole frame
      bias = 16'd0; pop_cnt = 0;
      drive_frame(25, -1, 0, 1);
      idle(2, 1'b0);
      check("stall_overflow", {31'd0, overflow}, 32'd1);
      check("stall_held", {31'd0, out_valid}, 32'd1);
      check("stall_no_pop", pop_cnt, 0);
      idle(6, 1'b1);
      check("stall_drained", pop_cnt, 4);

      // reset with three entries queued
      drive_frame(15, -1, 0, 1);
      idle(1, 1'b0);
      do_reset();
      pop_cnt = 0; fd_seen = 0;
      drive_frame(25, -1, 0, 0);
      idle(4, 1'b1);
      check("post_rst_outputs", pop_cnt, 9);
      check("post_rst_frame_done", fd_seen, 1);

      // full FIFO with pop and push on the same edge
      pop_cnt = 0;
      drive_frame(25, -1, 2, 2);
      idle(6, 1'b1);
      check("fullpop_no_overflow", {31'd0, overflow}, 32'd0);
      check("fullpop_outputs", pop_cnt, 9);

      // sof reasserted at (2,3): partial frame, then a full frame
      pop_cnt = 0; fd_seen = 0;
      drive_frame(38, 13, 0, 0);
      idle(4, 1'b1);
      check("restart_outputs", pop_cnt, 10);
      check("restart_frame_done", fd_seen, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
